uart_transmitter: RTL and testbench

Serial UART transmit stage. It accepts bytes from the host side over a four-phase req/ack handshake and buffers one byte while another is on the line. It serializes each byte onto the single serial line consumed by the design's UART receiver. The frame layout and bit timing match that receiver exactly, so a loopback of txd into the receiver reproduces the byte.

---
 rtl/uart_transmitter.sv | 177 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit stage.
// Host bytes arrive over a four-phase req/ack handshake into a one-byte
// holding register. The transmit FSM serializes each byte as:
// start(0), data[1..7], data[0], then STOP_BITS stop slots (1).
// That bit order matches the companion receiver, so a loopback reproduces the byte.
// When a byte is waiting at the end of the stop period, the next start bit
// follows immediately, so back-to-back frames have no idle gap.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 5220,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic       txd,
    output logic       busy
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [0:0]     STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic {
        HS_WAIT,
        HS_ACK
    } hs_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    hs_state_t      hs_state_reg;
    tx_state_t      tx_state_reg;
    logic [7:0]     hold_reg;
    logic           hold_full_reg;
    logic [7:0]     shift_reg;
    logic [CW-1:0]  baud_reg;
    logic [2:0]     slot_reg;
    logic [0:0]     stop_reg;
    logic           ack_reg;
    logic           txd_reg;
    logic           busy_reg;

    logic           baud_end;
    logic           stop_end;
    logic           load;
    logic           capture;
    logic           hold_full_next;
    logic           tx_idle_next;

    // Shared decode between the two FSMs. The hold register hands over to the
    // shifter only when a byte is held, so a capture can never coincide with a load.
    always_comb begin
        baud_end       = (baud_reg == BAUD_LAST);
        stop_end       = (tx_state_reg == TX_STOP) && baud_end && (stop_reg == STOP_LAST);
        load           = hold_full_reg && ((tx_state_reg == TX_IDLE) || stop_end);
        capture        = (hs_state_reg == HS_WAIT) && req && !hold_full_reg;
        hold_full_next = capture || (hold_full_reg && !load);
        tx_idle_next   = ((tx_state_reg == TX_IDLE) || stop_end) && !hold_full_reg;
    end

    // Handshake FSM: capture into the holding register, then wait for req to drop.
    always_ff @(posedge clk) begin
        if (!clr) begin
            hs_state_reg  <= HS_WAIT;
            ack_reg       <= 1'b0;
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
        end else begin
            hold_full_reg <= hold_full_next;
            case (hs_state_reg)
                HS_WAIT: begin
                    if (capture) begin
                        hold_reg     <= data;
                        ack_reg      <= 1'b1;
                        hs_state_reg <= HS_ACK;
                    end
                end
                HS_ACK: begin
                    if (!req) begin
                        ack_reg      <= 1'b0;
                        hs_state_reg <= HS_WAIT;
                    end
                end
                default: begin
                    ack_reg      <= 1'b0;
                    hs_state_reg <= HS_WAIT;
                end
            endcase
        end
    end

    // Transmit FSM: start slot, eight data slots, stop slots; reload straight from stop.
    always_ff @(posedge clk) begin
        if (!clr) begin
            tx_state_reg <= TX_IDLE;
            txd_reg      <= 1'b1;
            shift_reg    <= 8'h00;
            baud_reg     <= '0;
            slot_reg     <= 3'd0;
            stop_reg     <= 1'b0;
        end else if (load) begin
            shift_reg    <= hold_reg;
            txd_reg      <= 1'b0;
            baud_reg     <= '0;
            tx_state_reg <= TX_START;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    txd_reg <= 1'b1;
                end
                TX_START: begin
                    if (baud_end) begin
                        baud_reg     <= '0;
                        slot_reg     <= 3'd0;
                        txd_reg      <= shift_reg[1];
                        tx_state_reg <= TX_DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_end) begin
                        baud_reg <= '0;
                        if (slot_reg == 3'd7) begin
                            txd_reg      <= 1'b1;
                            stop_reg     <= 1'b0;
                            tx_state_reg <= TX_STOP;
                        end else begin
                            slot_reg <= slot_reg + 3'd1;
                            // slot k carries bit (k+1) mod 8; the 3-bit sum wraps onto bit 0
                            txd_reg  <= shift_reg[3'(slot_reg + 3'd2)];
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                TX_STOP: begin
                    txd_reg <= 1'b1;
                    if (baud_end) begin
                        baud_reg <= '0;
                        if (stop_reg == STOP_LAST) begin
                            tx_state_reg <= TX_IDLE;
                        end else begin
                            stop_reg <= stop_reg + 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    txd_reg      <= 1'b1;
                    tx_state_reg <= TX_IDLE;
                end
            endcase
        end
    end

    // Busy tracks the next-state view so it lines up with the state registers.
    always_ff @(posedge clk) begin
        if (!clr) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= !tx_idle_next || hold_full_next;
        end
    end

    assign ack  = ack_reg;
    assign txd  = txd_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter. It instantiates two units:
//   unit 0 has one stop bit, and unit 1 has two.
// A serial monitor per unit decodes txd and compares each frame against a
// queue of bytes pushed when the handshake captures them.
module tb_uart_transmitter;

    localparam int C   = 16;
    localparam int LIM = 400;

    logic       clk;
    logic       clr;
    logic [1:0] req_w;
    logic [7:0] data_w [2];
    logic [1:0] ack_w;
    logic [1:0] txd_w;
    logic [1:0] busy_w;

    int         asserts;
    int         fails;
    int         cyc;
    logic [7:0] exp_q  [2][$];
    int         starts [2][$];

    uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk  (clk),
        .clr  (clr),
        .req  (req_w[0]),
        .data (data_w[0]),
        .ack  (ack_w[0]),
        .txd  (txd_w[0]),
        .busy (busy_w[0])
    );

    uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk  (clk),
        .clr  (clr),
        .req  (req_w[1]),
        .data (data_w[1]),
        .ack  (ack_w[1]),
        .txd  (txd_w[1]),
        .busy (busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Serial monitor per unit: sample each data slot mid-bit,
    // check every start/stop cycle, and score the decoded byte.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int SB = gi + 1;
        logic       active = 1'b0;
        int         k;
        logic [7:0] rx;
        logic [7:0] exp_b;
        always @(negedge clk) begin
            if (clr !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (txd_w[gi] === 1'b0) begin
                    active = 1'b1;
                    k = 0;
                    starts[gi].push_back(cyc);
                end
            end else begin
                k = k + 1;
            end
            if (active) begin
                if (k / C == 0) begin
                    asserts++;
                    if (txd_w[gi] !== 1'b0) begin
                        fails++;
                        $display("FAIL mon%0d_start k=%0d txd=%b expected 0", gi, k, txd_w[gi]);
                    end
                end else if (k / C <= 8) begin
                    if (k % C == C / 2) rx[(k / C) % 8] = txd_w[gi];
                end else begin
                    asserts++;
                    if (txd_w[gi] !== 1'b1) begin
                        fails++;
                        $display("FAIL mon%0d_stop k=%0d txd=%b expected 1", gi, k, txd_w[gi]);
                    end
                end
                if (k == (9 + SB) * C - 1) begin
                    active = 1'b0;
                    asserts++;
                    if (exp_q[gi].size() == 0) begin
                        fails++;
                        $display("FAIL mon%0d_byte got %h expected none", gi, rx);
                    end else begin
                        exp_b = exp_q[gi].pop_front();
                        if (rx !== exp_b) begin
                            fails++;
                            $display("FAIL mon%0d_byte got %h expected %h", gi, rx, exp_b);
                        end
                    end
                    $display("unit%0d frame byte %h at cycle %0d", gi, rx, cyc);
                end
            end
        end
    end

    // Full four-phase handshake on one unit; queues the byte once it is captured.
    task automatic handshake(input int d, input logic [7:0] b);
        int n;
        @(negedge clk);
        req_w[d]  = 1'b1;
        data_w[d] = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_w[d] !== 1'b1 && n < LIM);
        asserts++;
        if (ack_w[d] !== 1'b1) begin
            fails++;
            $display("FAIL hs%0d_ack got %b expected 1 within %0d cycles", d, ack_w[d], LIM);
        end
        exp_q[d].push_back(b);
        data_w[d] = 8'($urandom);
        req_w[d]  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_w[d] !== 1'b0 && n < LIM);
        asserts++;
        if (ack_w[d] !== 1'b0) begin
            fails++;
            $display("FAIL hs%0d_ack_release got %b expected 0", d, ack_w[d]);
        end
    endtask

    task automatic wait_idle(input int d);
        int   n;
        logic mact;
        n = 0;
        mact = (d == 0) ? g_mon[0].active : g_mon[1].active;
        while ((exp_q[d].size() != 0 || busy_w[d] !== 1'b0 || mact) && n < 3000) begin
            @(negedge clk);
            n++;
            mact = (d == 0) ? g_mon[0].active : g_mon[1].active;
        end
        asserts++;
        if (exp_q[d].size() != 0 || busy_w[d] !== 1'b0) begin
            fails++;
            $display("FAIL idle%0d pending=%0d busy=%b expected 0/0", d, exp_q[d].size(), busy_w[d]);
        end
    endtask

    task automatic test_reset;
        clr       = 1'b0;
        req_w     = 2'b01;
        data_w[0] = 8'hFF;
        data_w[1] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            asserts++;
            if (txd_w !== 2'b11 || ack_w !== 2'b00 || busy_w !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold got txd=%b ack=%b busy=%b expected 11/00/00", txd_w, ack_w, busy_w);
            end
        end
        clr = 1'b1;
        @(negedge clk);
        asserts++;
        if (ack_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ack got %b expected 1", ack_w[0]);
        end
        exp_q[0].push_back(8'hFF);
        req_w[0] = 1'b0;
        wait_idle(0);
        $display("test_reset done");
    endtask

    task automatic test_single;
        logic [7:0] b;
        logic       e;
        int         s;
        b = 8'hA5;
        @(negedge clk);
        req_w[0]  = 1'b1;
        data_w[0] = b;
        @(negedge clk);
        asserts++;
        if (ack_w[0] !== 1'b1 || txd_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_latency got ack=%b txd=%b busy=%b expected 1/1/1", ack_w[0], txd_w[0], busy_w[0]);
        end
        exp_q[0].push_back(b);
        data_w[0] = 8'h00;
        for (int k = 0; k <= 10 * C; k++) begin
            @(negedge clk);
            if (k == 0) req_w[0] = 1'b0;
            s = k / C;
            if (s == 0)      e = 1'b0;
            else if (s <= 8) e = b[s % 8];
            else             e = 1'b1;
            asserts++;
            if (txd_w[0] !== e) begin
                fails++;
                $display("FAIL single_txd k=%0d got %b expected %b", k, txd_w[0], e);
            end
            if (k == 1) begin
                asserts++;
                if (ack_w[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL single_ack_drop got %b expected 0", ack_w[0]);
                end
            end
            if (k == 10 * C - 1 || k == 10 * C) begin
                asserts++;
                if (busy_w[0] !== (k == 10 * C - 1)) begin
                    fails++;
                    $display("FAIL single_busy k=%0d got %b expected %b", k, busy_w[0], k == 10 * C - 1);
                end
            end
        end
        wait_idle(0);
        $display("test_single done");
    endtask

    task automatic test_back_to_back;
        starts[0].delete();
        handshake(0, 8'h00);
        handshake(0, 8'hFF);
        wait_idle(0);
        asserts++;
        if (starts[0].size() != 2 || starts[0][1] - starts[0][0] != 10 * C) begin
            fails++;
            $display("FAIL b2b_spacing frames=%0d got %0d expected %0d", starts[0].size(),
                     (starts[0].size() == 2) ? starts[0][1] - starts[0][0] : -1, 10 * C);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_stall;
        int n;
        int rise;
        starts[0].delete();
        handshake(0, 8'h11);
        handshake(0, 8'h22);
        @(negedge clk);
        req_w[0]  = 1'b1;
        data_w[0] = 8'h33;
        n = 0;
        while (ack_w[0] !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        rise = cyc;
        asserts++;
        if (ack_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL stall_ack got %b expected 1", ack_w[0]);
        end
        asserts++;
        if (starts[0].size() != 2 || rise != starts[0][1] + 1) begin
            fails++;
            $display("FAIL stall_ack_time got cycle %0d expected frame2 start+1 (frames=%0d)", rise, starts[0].size());
        end
        exp_q[0].push_back(8'h33);
        data_w[0] = 8'h00;
        req_w[0]  = 1'b0;
        wait_idle(0);
        asserts++;
        if (starts[0].size() != 3 || starts[0][2] - starts[0][1] != 10 * C) begin
            fails++;
            $display("FAIL stall_frames got %0d frames expected 3 with spacing %0d", starts[0].size(), 10 * C);
        end
        $display("test_stall done");
    endtask

    task automatic test_reset_mid;
        int n;
        int st;
        starts[0].delete();
        handshake(0, 8'h5A);
        n = 0;
        while (starts[0].size() == 0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (starts[0].size() == 0) begin
            fails++;
            $display("FAIL mid_frame_start got none expected a frame");
            st = cyc;
        end else begin
            st = starts[0][0];
        end
        while (cyc < st + 70) @(negedge clk);
        void'(exp_q[0].pop_back());
        clr = 1'b0;
        @(negedge clk);
        asserts++;
        if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ack_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got txd=%b busy=%b ack=%b expected 1/0/0", txd_w[0], busy_w[0], ack_w[0]);
        end
        @(negedge clk);
        clr = 1'b1;
        handshake(0, 8'h3C);
        wait_idle(0);
        $display("test_reset_mid done");
    endtask

    task automatic test_two_stop;
        starts[1].delete();
        handshake(1, 8'h81);
        handshake(1, 8'h18);
        wait_idle(1);
        asserts++;
        if (starts[1].size() != 2 || starts[1][1] - starts[1][0] != 11 * C) begin
            fails++;
            $display("FAIL two_stop_spacing frames=%0d got %0d expected %0d", starts[1].size(),
                     (starts[1].size() == 2) ? starts[1][1] - starts[1][0] : -1, 11 * C);
        end
        $display("test_two_stop done");
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        cyc     = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_two_stop();
        asserts++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            fails++;
            $display("FAIL leftover got %0d/%0d expected 0/0", exp_q[0].size(), exp_q[1].size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
